// File: rtl/matinv_seq_ctrl.sv
// Sequencer for the 5x5 matrix-inverse datapath: serial load, fixed latency wait, buffered result drain.
// Define MATINV_ABORT_EN to add an abort input that returns the sequencer to idle from any state.
module matinv_seq_ctrl #(
    parameter int DW      = 32,
    parameter int N       = 5,
    parameter int INV_LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MATINV_ABORT_EN
    input  logic                abort,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic [N*N*DW-1:0]   mat_flat,
    output logic                inv_start,
    input  logic [N*N*DW-1:0]   inv_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int NE  = N * N;
    localparam int CW  = $clog2(NE);
    localparam int WCW = $clog2(INV_LAT + 1);

    localparam logic [CW-1:0]  LAST_K    = CW'(NE - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(INV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       in_cnt_q, in_cnt_d;
    logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [CW-1:0]       out_cnt_q, out_cnt_d;
    logic [NE*DW-1:0]    mat_q, mat_d;
    logic [NE*DW-1:0]    res_q, res_d;
    logic                inv_start_q, inv_start_d;
    logic                in_hs;
    logic                out_hs;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = out_valid && (out_cnt_q == LAST_K);
    assign busy      = (state_q != S_IDLE);
    assign mat_flat  = mat_q;
    assign inv_start = inv_start_q;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // The result buffer, not inv_flat, feeds the output so later datapath changes cannot leak out.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NE; k++) begin
            if (out_valid && (out_cnt_q == CW'(k))) begin
                out_data = res_q[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        out_cnt_d   = out_cnt_q;
        mat_d       = mat_q;
        res_d       = res_q;
        inv_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    mat_d[DW-1:0] = in_data;
                    in_cnt_d      = CW'(1);
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_hs) begin
                    for (int k = 1; k < NE; k++) begin
                        if (in_cnt_q == CW'(k)) begin
                            mat_d[k*DW +: DW] = in_data;
                        end
                    end
                    if (in_cnt_q == LAST_K) begin
                        in_cnt_d    = '0;
                        wait_cnt_d  = '0;
                        inv_start_d = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    res_d      = inv_flat;
                    out_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = S_DRAIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    if (out_cnt_q == LAST_K) begin
                        out_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MATINV_ABORT_EN
        // Abort wins over any same-cycle beat, so that beat must leave no trace in the buffers.
        if (abort) begin
            state_d     = S_IDLE;
            in_cnt_d    = '0;
            wait_cnt_d  = '0;
            out_cnt_d   = '0;
            mat_d       = mat_q;
            res_d       = res_q;
            inv_start_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            out_cnt_q   <= '0;
            mat_q       <= '0;
            res_q       <= '0;
            inv_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            out_cnt_q   <= out_cnt_d;
            mat_q       <= mat_d;
            res_q       <= res_d;
            inv_start_q <= inv_start_d;
        end
    end

endmodule
